// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN                = 32;
    localparam int unsigned STRB_W              = XLEN / 8;
    localparam int unsigned LSU_DEFAULT_TIMEOUT = 255;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extraction/extension, store strobes and
// lane replication, and the misalignment check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic [XLEN-1:0]   load_data,
    output logic [STRB_W-1:0] wstrb,
    output logic [XLEN-1:0]   wdata_lane,
    output logic              misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the raw bus word.
    always_comb begin
        byte_sel = bus_rdata[7:0];
        case (addr_lo)
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            2'd3:    byte_sel = bus_rdata[31:24];
            default: byte_sel = bus_rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    end

    // Sign- or zero-extend the selected field.
    always_comb begin
        load_data = bus_rdata;
        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data = {24'd0, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data = {16'd0, half_sel};
            default: load_data = bus_rdata;
        endcase
    end

    // Store strobes and per-lane replicated write data.
    always_comb begin
        wstrb      = 4'b1111;
        wdata_lane = wdata;
        case (funct3)
            F3_SB: begin
                wstrb      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            F3_SH: begin
                wstrb      = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
            end
            default: begin
                wstrb      = 4'b1111;
                wdata_lane = wdata;
            end
        endcase
    end

    // Halfwords must be 2-byte aligned, words 4-byte aligned.
    always_comb begin
        misaligned = 1'b0;
        if (funct3 == F3_LH || funct3 == F3_LHU) begin
            misaligned = addr_lo[0];
        end else if (funct3 == F3_LW || funct3 == F3_SW) begin
            misaligned = |addr_lo;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine on a single-outstanding word bus.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_DEFAULT_TIMEOUT
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata,
    output logic              valid,
    output logic              misaligned,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [STRB_W-1:0] bus_wstrb,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata
);

    lsu_state_e        state, state_d;
    logic [1:0]        ofs_q, ofs_d;
    logic [2:0]        f3_q, f3_d;

    logic [XLEN-1:0]   rdata_d;
    logic              valid_d, mis_d, err_d, req_d, we_d;
    logic [XLEN-1:0]   bus_addr_d, bus_wdata_d;
    logic [STRB_W-1:0] bus_wstrb_d;

    logic [1:0]        al_ofs;
    logic [2:0]        al_f3;
    logic [XLEN-1:0]   al_load, al_wdata;
    logic [STRB_W-1:0] al_wstrb;
    logic              al_mis;
    logic              timeout_c;

    // In IDLE the aligner sees the live request; afterwards the latched access.
    assign al_ofs = (state == S_IDLE) ? addr[1:0] : ofs_q;
    assign al_f3  = (state == S_IDLE) ? funct3    : f3_q;

    lsu_align u_align (
        .addr_lo    (al_ofs),
        .funct3     (al_f3),
        .wdata      (wdata),
        .bus_rdata  (bus_rdata),
        .load_data  (al_load),
        .wstrb      (al_wstrb),
        .wdata_lane (al_wdata),
        .misaligned (al_mis)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt;

    // Age of the current bus access; zero outside REQ/WAIT so it restarts on REQ entry.
    always_ff @(posedge clk) begin
        if (rst || (state != S_REQ && state != S_WAIT)) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign timeout_c = (state == S_REQ || state == S_WAIT) &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_c      = 1'b0;
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state;
        ofs_d       = ofs_q;
        f3_d        = f3_q;
        rdata_d     = rdata;
        valid_d     = 1'b0;
        mis_d       = 1'b0;
        err_d       = 1'b0;
        req_d       = bus_req;
        we_d        = bus_we;
        bus_addr_d  = bus_addr;
        bus_wstrb_d = bus_wstrb;
        bus_wdata_d = bus_wdata;

        case (state)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    ofs_d = addr[1:0];
                    f3_d  = funct3;
                    if (al_mis) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                        mis_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d     = S_REQ;
                        req_d       = 1'b1;
                        we_d        = ~mem_read;
                        bus_addr_d  = {addr[XLEN-1:2], 2'b00};
                        bus_wstrb_d = mem_read ? '0 : al_wstrb;
                        bus_wdata_d = al_wdata;
                    end
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    req_d = 1'b0;
                    if (bus_we) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (timeout_c) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    rdata_d = al_load;
                end else if (timeout_c) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ofs_q      <= '0;
            f3_q       <= '0;
            rdata      <= '0;
            valid      <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wstrb  <= '0;
            bus_wdata  <= '0;
        end else begin
            state      <= state_d;
            ofs_q      <= ofs_d;
            f3_q       <= f3_d;
            rdata      <= rdata_d;
            valid      <= valid_d;
            misaligned <= mis_d;
            bus_err    <= err_d;
            bus_req    <= req_d;
            bus_we     <= we_d;
            bus_addr   <= bus_addr_d;
            bus_wstrb  <= bus_wstrb_d;
            bus_wdata  <= bus_wdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a reactive bus model.
// The watchdog scenario runs only when LSU_TIMEOUT_EN is defined.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned TO     = 8;
    localparam int          BUDGET = 40;

    logic        clk, rst, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;
    logic        valid, misaligned, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt, bus_rvalid;

    int n_vec = 0;
    int n_err = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
        .valid(valid), .misaligned(misaligned), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int unsigned m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
        return (a % m_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
        int unsigned sz;
        logic [31:0] v, mask;
        sz = m_size(f3);
        if (sz == 4) return word;
        mask = (32'h1 << (8 * sz)) - 32'h1;
        v = (word >> (8 * (a % 4))) & mask;
        if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((32'h1 << m_size(f3)) - 32'h1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] v;
        int unsigned sz;
        sz = m_size(f3);
        v = '0;
        for (int k = 0; k < 4; k++) v[8 * k +: 8] = wd[8 * (k % sz) +: 8];
        return v;
    endfunction

    // ---------------- driver + bus responder (collects, never judges) ----------------
    task automatic do_access(
        input  logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
        input  logic [31:0] wd, input logic [31:0] word, input int gnt_dly, input int rv_dly,
        output int lat, output logic [31:0] o_rdata, output logic o_mis, output logic o_err,
        output int req_cycles, output logic [31:0] o_addr, output logic [3:0] o_strb,
        output logic [31:0] o_wdata, output logic o_we, output logic o_quiet);
        int gnt_cyc;
        lat = -1; o_rdata = 'x; o_mis = 1'bx; o_err = 1'bx; req_cycles = 0;
        o_addr = 'x; o_strb = 'x; o_wdata = 'x; o_we = 1'bx; o_quiet = 1'b0;
        gnt_cyc = -1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(posedge clk); #1;
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom();
            if (valid) begin
                lat = cyc; o_rdata = rdata; o_mis = misaligned; o_err = bus_err;
                break;
            end
            if (bus_req) begin
                if (req_cycles == 0) begin
                    o_addr = bus_addr; o_strb = bus_wstrb; o_wdata = bus_wdata; o_we = bus_we;
                end
                req_cycles++;
                bus_rvalid = 1'($urandom_range(0, 1));
                if (req_cycles > gnt_dly) begin bus_gnt = 1'b1; gnt_cyc = cyc; end
            end
            if (gnt_cyc > 0 && cyc == gnt_cyc + 1 + rv_dly) begin
                bus_rvalid = 1'b1; bus_rdata = word;
            end
        end
        if (lat > 0) begin
            @(posedge clk); #1;
            o_quiet = (valid === 1'b0) && (bus_req === 1'b0);
        end
        mem_read = 1'b0; mem_write = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (valid !== 1'b0)      begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_vec++; if (misaligned !== 1'b0) begin n_err++; $display("FAIL reset_misaligned: got %b expected 0", misaligned); end
        n_vec++; if (bus_err !== 1'b0)    begin n_err++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
        n_vec++; if (bus_req !== 1'b0)    begin n_err++; $display("FAIL reset_bus_req: got %b expected 0", bus_req); end
        n_vec++; if (bus_we !== 1'b0)     begin n_err++; $display("FAIL reset_bus_we: got %b expected 0", bus_we); end
        n_vec++; if (rdata !== 32'h0)     begin n_err++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        n_vec++; if (bus_addr !== 32'h0)  begin n_err++; $display("FAIL reset_bus_addr: got %h expected 0", bus_addr); end
        n_vec++; if (bus_wstrb !== 4'h0)  begin n_err++; $display("FAIL reset_bus_wstrb: got %h expected 0", bus_wstrb); end
        n_vec++; if (bus_wdata !== 32'h0) begin n_err++; $display("FAIL reset_bus_wdata: got %h expected 0", bus_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_lb();
        int lat, rq; logic [31:0] rd, ad, wdo; logic mi, er, we, q; logic [3:0] st;
        do_access(1'b1, 1'b0, F3_LB, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0,
                  lat, rd, mi, er, rq, ad, st, wdo, we, q);
        n_vec++; if (lat != 3)             begin n_err++; $display("FAIL lb_latency: got %0d expected 3", lat); end
        n_vec++; if (rd !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_rdata: got %h expected ffffff80", rd); end
        n_vec++; if (ad !== 32'h1000)      begin n_err++; $display("FAIL lb_bus_addr: got %h expected 00001000", ad); end
        n_vec++; if (we !== 1'b0)          begin n_err++; $display("FAIL lb_bus_we: got %b expected 0", we); end
        n_vec++; if (q !== 1'b1)           begin n_err++; $display("FAIL lb_single_pulse: got %b expected 1", q); end
    endtask

    task automatic test_lhu_delayed();
        int lat, rq; logic [31:0] rd, ad, wdo; logic mi, er, we, q; logic [3:0] st;
        do_access(1'b1, 1'b0, F3_LHU, 32'h2002, 32'h0, 32'h8001_0000, 0, 4,
                  lat, rd, mi, er, rq, ad, st, wdo, we, q);
        n_vec++; if (lat != 7)             begin n_err++; $display("FAIL lhu_latency: got %0d expected 7", lat); end
        n_vec++; if (rd !== 32'h0000_8001) begin n_err++; $display("FAIL lhu_rdata: got %h expected 00008001", rd); end
        n_vec++; if (q !== 1'b1)           begin n_err++; $display("FAIL lhu_single_pulse: got %b expected 1", q); end
    endtask

    task automatic test_sb();
        int lat, rq; logic [31:0] rd, ad, wdo; logic mi, er, we, q; logic [3:0] st;
        do_access(1'b0, 1'b1, F3_SB, 32'h3001, 32'h0000_00AB, 32'h0, 0, 0,
                  lat, rd, mi, er, rq, ad, st, wdo, we, q);
        n_vec++; if (lat != 2)              begin n_err++; $display("FAIL sb_latency: got %0d expected 2", lat); end
        n_vec++; if (st !== 4'b0010)        begin n_err++; $display("FAIL sb_wstrb: got %b expected 0010", st); end
        n_vec++; if (wdo !== 32'hABAB_ABAB) begin n_err++; $display("FAIL sb_wdata: got %h expected abababab", wdo); end
        n_vec++; if (ad !== 32'h3000)       begin n_err++; $display("FAIL sb_bus_addr: got %h expected 00003000", ad); end
        n_vec++; if (we !== 1'b1)           begin n_err++; $display("FAIL sb_bus_we: got %b expected 1", we); end
    endtask

    task automatic test_misaligned();
        int lat, rq; logic [31:0] rd, ad, wdo; logic mi, er, we, q; logic [3:0] st;
        do_access(1'b1, 1'b0, F3_LW, 32'h4002, 32'h0, 32'h1234_5678, 0, 0,
                  lat, rd, mi, er, rq, ad, st, wdo, we, q);
        n_vec++; if (lat != 1)       begin n_err++; $display("FAIL mis_latency: got %0d expected 1", lat); end
        n_vec++; if (mi !== 1'b1)    begin n_err++; $display("FAIL mis_flag: got %b expected 1", mi); end
        n_vec++; if (rd !== 32'h0)   begin n_err++; $display("FAIL mis_rdata: got %h expected 0", rd); end
        n_vec++; if (rq != 0)        begin n_err++; $display("FAIL mis_bus_req: got %0d req cycles expected 0", rq); end
    endtask

    task automatic test_reset_mid_wait();
        mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_LW; addr = 32'h5000;
        @(posedge clk); #1;
        n_vec++; if (bus_req !== 1'b1) begin n_err++; $display("FAIL rstwait_req_up: got %b expected 1", bus_req); end
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0;
        n_vec++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL rstwait_req_down: got %b expected 0", bus_req); end
        n_vec++; if (valid !== 1'b0)   begin n_err++; $display("FAIL rstwait_valid: got %b expected 0", valid); end
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (valid !== 1'b0 || bus_req !== 1'b0 || rdata !== 32'h0) begin
                n_err++; $display("FAIL rstwait_late_rvalid%0d: got valid=%b req=%b rdata=%h expected 0 0 0", i, valid, bus_req, rdata);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int lat, rq; logic [31:0] rd, ad, wdo, exp; logic mi, er, we, q; logic [3:0] st;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, w;
            a = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'(4 * $urandom_range(0, 3));
            w = $urandom();
            if (i % 2 == 0) begin
                do_access(1'b1, 1'b0, F3_LW, a, 32'h0, w, 0, 0, lat, rd, mi, er, rq, ad, st, wdo, we, q);
                exp = 3;
                n_vec++; if (rd !== w) begin n_err++; $display("FAIL b2b%0d_rdata: got %h expected %h", i, rd, w); end
            end else begin
                do_access(1'b0, 1'b1, F3_SW, a, w, 32'h0, 0, 0, lat, rd, mi, er, rq, ad, st, wdo, we, q);
                exp = 2;
                n_vec++; if (wdo !== w || st !== 4'hF) begin n_err++; $display("FAIL b2b%0d_store: got %h/%b expected %h/1111", i, wdo, st, w); end
            end
            n_vec++; if (lat != int'(exp)) begin n_err++; $display("FAIL b2b%0d_latency: got %0d expected %0d", i, lat, exp); end
            n_vec++; if (q !== 1'b1)       begin n_err++; $display("FAIL b2b%0d_quiet_after: got %b expected 1", i, q); end
        end
    endtask

    task automatic test_random(input int n);
        int lat, rq, gd, rvd, exp_lat, sel;
        logic [31:0] rd, ad, wdo, a, w, word;
        logic mi, er, we, q, is_rd, is_wr, exp_mis;
        logic [2:0] f3;
        logic [3:0] st;
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 9);
            is_rd = (sel < 5) || (sel == 9);
            is_wr = (sel >= 5);
            if (is_rd) begin
                case ($urandom_range(0, 4))
                    0: f3 = F3_LB; 1: f3 = F3_LH; 2: f3 = F3_LW; 3: f3 = F3_LBU; default: f3 = F3_LHU;
                endcase
            end else begin
                case ($urandom_range(0, 2))
                    0: f3 = F3_SB; 1: f3 = F3_SH; default: f3 = F3_SW;
                endcase
            end
            a = $urandom();
            if ($urandom_range(0, 3) != 0) a = a & ~32'(m_size(f3) - 1);
            w = $urandom(); word = $urandom();
            gd = $urandom_range(0, 2); rvd = $urandom_range(0, 2);
            do_access(is_rd, is_wr, f3, a, w, word, gd, rvd, lat, rd, mi, er, rq, ad, st, wdo, we, q);
            exp_mis = m_mis(f3, a);
            exp_lat = exp_mis ? 1 : (is_rd ? 3 + gd + rvd : 2 + gd);
            n_vec++; if (lat != exp_lat) begin n_err++; $display("FAIL rnd%0d_latency: got %0d expected %0d (f3=%b a=%h rd=%b)", i, lat, exp_lat, f3, a, is_rd); end
            n_vec++; if (mi !== exp_mis) begin n_err++; $display("FAIL rnd%0d_misaligned: got %b expected %b", i, mi, exp_mis); end
            n_vec++; if (er !== 1'b0)    begin n_err++; $display("FAIL rnd%0d_bus_err: got %b expected 0", i, er); end
            n_vec++; if (q !== 1'b1)     begin n_err++; $display("FAIL rnd%0d_quiet_after: got %b expected 1", i, q); end
            if (exp_mis) begin
                n_vec++; if (rd !== 32'h0 || rq != 0) begin n_err++; $display("FAIL rnd%0d_mis_side: got rdata=%h req=%0d expected 0 0", i, rd, rq); end
            end else begin
                n_vec++; if (rq != gd + 1) begin n_err++; $display("FAIL rnd%0d_req_cycles: got %0d expected %0d", i, rq, gd + 1); end
                n_vec++; if (ad !== {a[31:2], 2'b00} || we !== !is_rd) begin n_err++; $display("FAIL rnd%0d_bus_hdr: got %h/%b expected %h/%b", i, ad, we, {a[31:2], 2'b00}, !is_rd); end
                if (is_rd) begin
                    n_vec++; if (rd !== m_load(f3, a, word)) begin n_err++; $display("FAIL rnd%0d_rdata: got %h expected %h", i, rd, m_load(f3, a, word)); end
                end else begin
                    n_vec++; if (st !== m_strb(f3, a))   begin n_err++; $display("FAIL rnd%0d_wstrb: got %b expected %b", i, st, m_strb(f3, a)); end
                    n_vec++; if (wdo !== m_lanes(f3, w)) begin n_err++; $display("FAIL rnd%0d_wdata: got %h expected %h", i, wdo, m_lanes(f3, w)); end
                end
            end
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int lat, rq; logic [31:0] rd, ad, wdo; logic mi, er, we, q; logic [3:0] st;
        do_access(1'b1, 1'b0, F3_LW, 32'h6000, 32'h0, 32'h0, 1000, 0,
                  lat, rd, mi, er, rq, ad, st, wdo, we, q);
        n_vec++; if (lat != int'(TO) + 1) begin n_err++; $display("FAIL tmo_latency: got %0d expected %0d", lat, TO + 1); end
        n_vec++; if (er !== 1'b1)         begin n_err++; $display("FAIL tmo_bus_err: got %b expected 1", er); end
        n_vec++; if (rd !== 32'h0)        begin n_err++; $display("FAIL tmo_rdata: got %h expected 0", rd); end
        n_vec++; if (rq != int'(TO))      begin n_err++; $display("FAIL tmo_req_cycles: got %0d expected %0d", rq, TO); end
        n_vec++; if (q !== 1'b1)          begin n_err++; $display("FAIL tmo_quiet_after: got %b expected 1", q); end
    endtask
`endif

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0;
        addr = '0; wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        test_reset();
        test_lb();
        test_lhu_delayed();
        test_sb();
        test_misaligned();
        test_reset_mid_wait();
        test_back_to_back();
        test_random(80);
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
